// File: rtl/i2c_line_frontend.sv
// +--------------------------------------------------------------------------+
// | i2c_line_frontend                                                        |
// | SCL/SDA synchronizer, glitch filter, START/STOP detect, byte deserializer|
// | Optional feature macro: I2C_TIMEOUT_EN (SCL-low bus timeout)             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2c_line_frontend #(
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       bus_busy,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_ack,
    output logic       byte_first,
    output logic       frame_err,
    output logic       bus_timeout
);

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0] raw_w;
    logic [1:0] filt_w;
    logic [1:0] dly_w;

    assign raw_w = {sda_in, scl_in};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_line
            logic [1:0] sync_q;
            logic [3:0] cnt_q;
            logic       filt_q;
            logic       dly_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= 2'b11;
                    cnt_q  <= 4'd0;
                    filt_q <= 1'b1;
                    dly_q  <= 1'b1;
                end else begin
                    sync_q <= {sync_q[0], raw_w[i]};
                    dly_q  <= filt_q;
                    if (sync_q[1] == filt_q) begin
                        cnt_q <= 4'd0;
                    end else if (cnt_q == FILT_LAST) begin
                        cnt_q  <= 4'd0;
                        filt_q <= ~filt_q;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end

            assign filt_w[i] = filt_q;
            assign dly_w[i]  = dly_q;
        end
    endgenerate

    assign scl_f = filt_w[0];
    assign sda_f = filt_w[1];

    // SCL must be high in both cycles, so a simultaneous SCL edge suppresses START/STOP.
    logic w_start;
    logic w_stop;
    logic w_scl_rise;
    logic w_timeout;

    assign w_start    = filt_w[0] & dly_w[0] & ~filt_w[1] &  dly_w[1];
    assign w_stop     = filt_w[0] & dly_w[0] &  filt_w[1] & ~dly_w[1];
    assign w_scl_rise = filt_w[0] & ~dly_w[0];

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       first_q, first_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;
    logic       rstart_q, rstart_d;
    logic       stop_q, stop_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       to_q, to_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d;
    logic       bfirst_q, bfirst_d;
    logic       w_partial;

`ifdef I2C_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    assign w_timeout = busy_q & ~scl_f & (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset || !busy_q || scl_f || w_timeout) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_w;

    assign unused_timeout_w = |TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // A byte is broken if data bits are pending or the ACK slot was not clocked.
    assign w_partial = ((state_q == S_DATA) && (bit_cnt_q != 4'd0)) || (state_q == S_ACK);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        first_d   = first_q;
        busy_d    = busy_q;
        start_d   = 1'b0;
        rstart_d  = 1'b0;
        stop_d    = 1'b0;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        to_d      = 1'b0;
        data_d    = data_q;
        ack_d     = ack_q;
        bfirst_d  = bfirst_q;

        if (w_start) begin
            start_d   = 1'b1;
            rstart_d  = busy_q;
            ferr_d    = w_partial;
            bit_cnt_d = 4'd0;
            first_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = S_DATA;
        end else if (w_stop) begin
            stop_d    = 1'b1;
            ferr_d    = w_partial;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
        end else if (w_timeout) begin
            to_d      = 1'b1;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (w_scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (w_scl_rise) begin
                        valid_d   = 1'b1;
                        data_d    = shreg_q;
                        ack_d     = ~sda_f;
                        bfirst_d  = first_q;
                        first_d   = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'd0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            rstart_q  <= 1'b0;
            stop_q    <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            to_q      <= 1'b0;
            data_q    <= 8'd0;
            ack_q     <= 1'b0;
            bfirst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            rstart_q  <= rstart_d;
            stop_q    <= stop_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            to_q      <= to_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            bfirst_q  <= bfirst_d;
        end
    end

    assign bus_busy    = busy_q;
    assign start_det   = start_q;
    assign rstart_det  = rstart_q;
    assign stop_det    = stop_q;
    assign byte_valid  = valid_q;
    assign byte_data   = data_q;
    assign byte_ack    = ack_q;
    assign byte_first  = bfirst_q;
    assign frame_err   = ferr_q;
    assign bus_timeout = to_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_line_frontend.sv
// +--------------------------------------------------------------------------+
// | tb_i2c_line_frontend                                                     |
// | Randomized bus traffic against an event-level reference model            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_line_frontend;

`ifdef I2C_TIMEOUT_EN
    localparam int TO_CYC = 50;
`else
    localparam int TO_CYC = 100000;
`endif

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_STOP  = 2'd1;
    localparam logic [1:0] K_BYTE  = 2'd2;
    localparam logic [1:0] K_TO    = 2'd3;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_f, sda_f, bus_busy, start_det, rstart_det, stop_det;
    logic       byte_valid, byte_ack, byte_first, frame_err, bus_timeout;
    logic [7:0] byte_data;

    always #5 clk = ~clk;

    i2c_line_frontend #(
        .FILTER_LEN     (3),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl_f       (scl_f),
        .sda_f       (sda_f),
        .bus_busy    (bus_busy),
        .start_det   (start_det),
        .rstart_det  (rstart_det),
        .stop_det    (stop_det),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ack    (byte_ack),
        .byte_first  (byte_first),
        .frame_err   (frame_err),
        .bus_timeout (bus_timeout)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Event-level reference model: what the decoder should see, in order.
    typedef struct packed {
        logic [1:0] kind;
        logic       rstart;
        logic       ferr;
        logic [7:0] data;
        logic       ack;
        logic       first;
    } ev_t;

    ev_t        evq[$];
    bit         m_busy  = 1'b0;
    bit         m_first = 1'b0;
    int         m_bits  = 0;
    logic [7:0] m_sh    = 8'd0;

    function automatic void m_push(input logic [1:0] k, input logic rs, input logic fe,
                                   input logic [7:0] d, input logic a, input logic f);
        ev_t e;
        e.kind = k; e.rstart = rs; e.ferr = fe; e.data = d; e.ack = a; e.first = f;
        evq.push_back(e);
    endfunction

    function automatic void m_rise(input logic b);
        if (!m_busy) return;
        if (m_bits < 8) begin
            m_sh = 8'((int'(m_sh) * 2 + int'(b)) % 256);
            m_bits++;
        end else begin
            m_push(K_BYTE, 1'b0, 1'b0, m_sh, !b, m_first);
            m_first = 1'b0;
            m_bits  = 0;
        end
    endfunction

    function automatic void m_start();
        m_push(K_START, m_busy, m_busy && (m_bits != 0), 8'd0, 1'b0, 1'b0);
        m_busy = 1'b1; m_bits = 0; m_first = 1'b1;
    endfunction

    function automatic void m_stop();
        m_push(K_STOP, 1'b0, m_busy && (m_bits != 0), 8'd0, 1'b0, 1'b0);
        m_busy = 1'b0; m_bits = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int h);
        sda_in = b;  tick(h);
        scl_in = 1'b1; m_rise(b); tick(h);
        scl_in = 1'b0; tick(h);
    endtask

    task automatic send_start(input int h);
        if (scl_in == 1'b0) begin
            sda_in = 1'b1; tick(h);
            scl_in = 1'b1; m_rise(1'b1); tick(h);
        end else begin
            tick(h);
        end
        sda_in = 1'b0; m_start(); tick(h);
        scl_in = 1'b0; tick(h);
    endtask

    task automatic send_stop(input int h);
        sda_in = 1'b0; tick(h);
        scl_in = 1'b1; m_rise(1'b0); tick(h);
        sda_in = 1'b1; m_stop(); tick(h);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack, input int h);
        for (int i = 7; i >= 0; i--) send_bit(d[i], h);
        send_bit(~ack, h);
    endtask

    task automatic check_reset_state();
        check_eq("rst_scl_f", scl_f, 1'b1);
        check_eq("rst_sda_f", sda_f, 1'b1);
        check_eq("rst_bus_busy", bus_busy, 1'b0);
        check_eq("rst_byte_data", byte_data, 8'h00);
        check_eq("rst_byte_ack", byte_ack, 1'b0);
        check_eq("rst_byte_first", byte_first, 1'b0);
        check_eq("rst_pulses", {start_det, rstart_det, stop_det, byte_valid, frame_err, bus_timeout}, 6'd0);
    endtask

    // Monitor: every DUT event pulse must match the next model event.
    int         stray   = 0;
    int         to_seen = 0;
    int         ev_seen = 0;
    int         mon_n;
    ev_t        mon_e;
    logic [1:0] mon_k;

    always @(negedge clk) begin
        if (!reset) begin
            mon_n = int'(start_det) + int'(stop_det) + int'(byte_valid) + int'(bus_timeout);
            if (bus_timeout) to_seen++;
            if (mon_n == 0) begin
                if (rstart_det || frame_err) stray++;
            end else if (mon_n > 1 || evq.size() == 0) begin
                stray++;
            end else begin
                mon_k = start_det ? K_START : stop_det ? K_STOP : byte_valid ? K_BYTE : K_TO;
                mon_e = evq.pop_front();
                ev_seen++;
                check_eq("ev_kind", mon_k, mon_e.kind);
                check_eq("rstart_det", rstart_det, mon_e.rstart);
                check_eq("frame_err", frame_err, mon_e.ferr);
                check_eq("ev_bus_busy", bus_busy, (mon_e.kind == K_START) || (mon_e.kind == K_BYTE));
                if (mon_k == K_BYTE && mon_e.kind == K_BYTE) begin
                    check_eq("byte_data", byte_data, mon_e.data);
                    check_eq("byte_ack", byte_ack, mon_e.ack);
                    check_eq("byte_first", byte_first, mon_e.first);
                end
            end
        end
    end

    initial begin
        int  h;
        int  len;
        int  nb;
        bit  low_seen;

        tick(3);
        check_reset_state();
        reset = 1'b0;
        tick(4);

        // Two-cycle SDA dip on an idle bus must not pass the filter.
        low_seen = 1'b0;
        sda_in = 1'b0; tick(2); sda_in = 1'b1;
        repeat (12) begin
            tick(1);
            if (!sda_f) low_seen = 1'b1;
        end
        check_eq("glitch2_sda_f_low", low_seen, 1'b0);

        // Three-cycle dip passes: START five edges after the first low sample, then STOP.
        m_start();
        m_stop();
        sda_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 3) sda_in = 1'b1;
            if (k == 4) check_eq("lat_sda_f_before", sda_f, 1'b1);
            if (k == 5) check_eq("lat_sda_f_flip", sda_f, 1'b0);
            if (k == 5) check_eq("lat_start_early", start_det, 1'b0);
            if (k == 6) check_eq("lat_start_det", start_det, 1'b1);
            if (k == 9) check_eq("lat_stop_det", stop_det, 1'b1);
        end
        tick(6);

        // Directed transfers.
        send_start(6);
        send_byte(8'h4A, 1'b1, 6);
        check_eq("hold_4a_data", byte_data, 8'h4A);
        check_eq("hold_4a_ack", byte_ack, 1'b1);
        check_eq("hold_4a_first", byte_first, 1'b1);
        check_eq("hold_4a_busy", bus_busy, 1'b1);
        send_stop(6);
        tick(6);

        send_start(6);
        send_byte(8'hA1, 1'b1, 6);
        send_start(6);
        send_byte(8'h18, 1'b0, 6);
        check_eq("rs_18_ack", byte_ack, 1'b0);
        check_eq("rs_18_first", byte_first, 1'b1);
        send_stop(6);
        tick(6);
        check_eq("stop_busy_low", bus_busy, 1'b0);

        send_start(6);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 6);
        send_stop(6);
        tick(6);

        // Randomized traffic.
        for (int op = 0; op < 40; op++) begin
            h = $urandom_range(4, 8);
            if (scl_in) begin
                case ($urandom_range(0, 2))
                    0, 1: send_start(h);
                    default: begin
                        len = $urandom_range(1, 2);
                        sda_in = 1'b0; tick(len); sda_in = 1'b1; tick(8);
                    end
                endcase
            end else begin
                case ($urandom_range(0, 5))
                    0, 1: send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), h);
                    2: begin
                        nb = $urandom_range(1, 8);
                        for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)), h);
                    end
                    3: send_start(h);
                    4: send_stop(h);
                    default: begin
                        len = $urandom_range(1, 2);
                        scl_in = 1'b1; tick(len); scl_in = 1'b0; tick(h);
                    end
                endcase
            end
        end
        if (!scl_in) send_stop(6);
        tick(10);

        // Reset in the middle of a byte, then a clean transfer.
        send_start(6);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 6);
        reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        m_busy = 1'b0; m_bits = 0; m_first = 1'b0; m_sh = 8'd0;
        tick(3);
        check_reset_state();
        check_eq("evq_empty_at_reset", evq.size(), 0);
        reset = 1'b0;
        tick(4);
        send_start(6);
        send_byte(8'h55, 1'b1, 6);
        check_eq("post_rst_data", byte_data, 8'h55);
        check_eq("post_rst_first", byte_first, 1'b1);
        send_stop(6);
        tick(10);

`ifdef I2C_TIMEOUT_EN
        send_start(6);
        m_push(K_TO, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        m_busy = 1'b0; m_bits = 0;
        tick(60);
        check_eq("timeout_count", to_seen, 1);
        check_eq("timeout_busy", bus_busy, 1'b0);
        scl_in = 1'b1; m_rise(1'b1); tick(6);
        sda_in = 1'b1; m_stop(); tick(10);
`else
        check_eq("timeout_count", to_seen, 0);
`endif

        check_eq("evq_drained", evq.size(), 0);
        check_eq("stray_pulses", stray, 0);
        check_eq("events_seen", ev_seen != 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
